data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the RI5CY data interface (req/gnt/rvalid) that the cache controller drives on its cache-to-memory port.
- Models word-organised data memory with byte-enable writes, programmable grant delay and programmable response latency.
- Serves as the bench memory and FPGA on-chip data RAM behind the trace-driven cache.
- Single outstanding transaction; all outputs registered.

Parameters:
ADDR_WIDTH, 16, byte address width
DATA_WIDTH, 32, data word width; only 32 supported
MEM_WORDS, 1024, memory depth in words; power of two
GNT_DELAY, 0, extra cycles between first sampled req and gnt (0..15)
RVALID_LATENCY, 1, cycles from gnt cycle to rvalid cycle (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
data_req_i  in  1  request valid; held by initiator until gnt sampled
data_addr_i  in  ADDR_WIDTH  byte address
data_we_i  in  1  1 = write, 0 = read
data_be_i  in  DATA_WIDTH/8  byte enables (writes only)
data_wdata_i  in  DATA_WIDTH  write data
data_gnt_o  out  1  one-cycle grant pulse
data_rvalid_o  out  1  one-cycle response pulse (reads and writes)
data_rdata_o  out  DATA_WIDTH  read data, valid with rvalid
oob_o  out  1  sticky: an access hit addr >= MEM_WORDS*4
txn_count_o  out  32  completed transactions (rvalid pulses), wraps

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; gnt_o=0, rvalid_o=0, rdata_o=0, oob_o=0, txn_count_o=0; delay counters cleared. Memory contents not cleared.
- Word index = data_addr_i[2 +: log2(MEM_WORDS)]; addr[1:0] ignored. Out-of-range addresses alias (wrap) and set oob_o.
- FSM states:
  - IDLE: when req_i is sampled high, go to GNT_WAIT with dcnt=0.
  - GNT_WAIT: if req_i drops, return to IDLE (no gnt). Otherwise, when dcnt==GNT_DELAY, drive gnt_o=1 next cycle and go to GRANT; else dcnt++. Earliest gnt is the cycle after req is first sampled (GNT_DELAY=0).
  - GRANT: gnt_o=1 for exactly this cycle. At the closing edge, capture addr/we/be/wdata. A write commits immediately, per enabled byte. A read latches mem[index], including a write committed on an earlier edge (read-after-write coherent). Go to RESP with lcnt=1.
  - RESP: req_i ignored. When lcnt==RVALID_LATENCY, drive rvalid_o=1 for one cycle with rdata = latched word (reads) or 0 (writes), and txn_count_o++. Otherwise lcnt++. Return to IDLE after the rvalid cycle.
  - With RVALID_LATENCY=1, rvalid follows the gnt cycle immediately.
- be=4'h0 write: no memory change; still granted and still gets rvalid.
- rdata_o returns to 0 in every cycle without rvalid.
- Back-to-back requests: next gnt is no earlier than 2 cycles after the previous rvalid (IDLE sample, then grant).
- Reset mid-transaction: aborts. A write already committed in GRANT stays committed; a pending rvalid is never issued; gnt/rvalid are 0 from the cycle after the reset edge.
- Elaboration error if RVALID_LATENCY<1, GNT_DELAY>15, DATA_WIDTH!=32, or MEM_WORDS not a power of two.

Optional Feature:
- Macro: DATA_MEM_RESPONDER_RANDOM_STALL_EN.
- Defined:
  - 8-bit Fibonacci LFSR (taps 8,6,5,4), seed 8'hA5 on reset, steps every cycle.
  - In GNT_WAIT, gnt is withheld in any cycle where lfsr[0]==1, even if dcnt==GNT_DELAY.
  - Stalls grants randomly to stress cache handshakes. Response path is unaffected.
- Undefined: grant timing is purely GNT_DELAY-deterministic and no LFSR exists.

Test Plan:
- GNT_DELAY=0, RVALID_LATENCY=1: write addr 16'h0010, wdata 32'hDEADBEEF, be 4'hF, then read 16'h0010 -> gnt 1 cycle after req; rvalid next cycle; read rdata=32'hDEADBEEF; txn_count_o=2.
- Byte enables: write 32'h11223344 full word, then write 32'hAABBCCDD with be=4'b0101 to the same address, then read -> rdata=32'h11BB33DD; write rvalids carry rdata=0.
- GNT_DELAY=3, RVALID_LATENCY=4: read -> gnt exactly 4 cycles after req first sampled; rvalid exactly 4 cycles after gnt cycle; req dropped in GNT_WAIT -> no gnt, no rvalid, txn_count unchanged.
- MEM_WORDS=1024: write 32'h5 to addr 16'h1004, read addr 16'h0004 -> rdata=32'h5 (aliased); oob_o=1 and stays 1 until reset.
- Reset asserted in the RESP cycle of a read (RVALID_LATENCY=3) -> no rvalid; outputs 0 the next cycle; txn_count_o=0; an earlier written word remains readable after reset.
- With DATA_MEM_RESPONDER_RANDOM_STALL_EN, 200 random reads/writes -> every req eventually granted; each gnt is followed by exactly one rvalid; data matches a scoreboard.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-organised data memory answering a req/gnt/rvalid port with a programmable grant delay and response latency.
// Define DATA_MEM_RESPONDER_RANDOM_STALL_EN to make grants stall pseudo-randomly (LFSR driven).
module data_mem_responder #(
   parameter int ADDR_WIDTH     = 16,
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_WORDS      = 1024,
   parameter int GNT_DELAY      = 0,
   parameter int RVALID_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    data_req_i,
   input  logic [ADDR_WIDTH-1:0]   data_addr_i,
   input  logic                    data_we_i,
   input  logic [DATA_WIDTH/8-1:0] data_be_i,
   input  logic [DATA_WIDTH-1:0]   data_wdata_i,
   output logic                    data_gnt_o,
   output logic                    data_rvalid_o,
   output logic [DATA_WIDTH-1:0]   data_rdata_o,
   output logic                    oob_o,
   output logic [31:0]             txn_count_o
);
   // state      | meaning
   // S_IDLE     | waiting for req; also the cycle carrying rvalid
   // S_GNT_WAIT | req seen, counting GNT_DELAY (and stalls) before grant
   // S_GRANT    | gnt_o high; request captured and committed at closing edge
   // S_RESP     | counting response latency until rvalid
   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_GNT_WAIT = 2'd1;
   localparam logic [1:0] S_GRANT    = 2'd2;
   localparam logic [1:0] S_RESP     = 2'd3;

   localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int          NB        = DATA_WIDTH / 8;
   localparam int unsigned MEM_BYTES = MEM_WORDS * 4;
   localparam logic [3:0]  DLY_LAST  = 4'(GNT_DELAY);
   localparam logic [3:0]  LAT_LAST  = 4'(RVALID_LATENCY - 1);

   if (RVALID_LATENCY < 1 || RVALID_LATENCY > 15) begin : g_bad_latency
      $error("data_mem_responder: RVALID_LATENCY must be 1..15");
   end
   if (GNT_DELAY < 0 || GNT_DELAY > 15) begin : g_bad_delay
      $error("data_mem_responder: GNT_DELAY must be 0..15");
   end
   if (DATA_WIDTH != 32) begin : g_bad_width
      $error("data_mem_responder: only DATA_WIDTH=32 is supported");
   end
   if (MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_depth
      $error("data_mem_responder: MEM_WORDS must be a power of two >= 2");
   end
   if (ADDR_WIDTH > 32 || ADDR_WIDTH < IDX_W + 2) begin : g_bad_addr
      $error("data_mem_responder: ADDR_WIDTH must cover the word index and be <= 32");
   end

   logic [1:0]            state;
   logic [3:0]            dcnt;
   logic [3:0]            lcnt;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] resp_word;
   logic [IDX_W-1:0]      idx;
   logic                  oob_hit;
   logic                  stall;
   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   assign idx       = data_addr_i[2 +: IDX_W];
   assign oob_hit   = 32'(data_addr_i) >= MEM_BYTES;
   assign resp_word = data_we_i ? '0 : mem[idx];

`ifdef DATA_MEM_RESPONDER_RANDOM_STALL_EN
   logic [7:0] lfsr;

   always_ff @(posedge clk) begin
      if (!rst_n) lfsr <= 8'hA5;
      else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign stall = lfsr[0];
`else
   assign stall = 1'b0;
`endif

   // Memory is never cleared; a write commits at the closing edge of the grant cycle.
   always_ff @(posedge clk) begin
      if (rst_n && state == S_GRANT && data_we_i) begin
         for (int b = 0; b < NB; b++) begin
            if (data_be_i[b]) mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         dcnt          <= '0;
         lcnt          <= '0;
         rd_word       <= '0;
         data_gnt_o    <= 1'b0;
         data_rvalid_o <= 1'b0;
         data_rdata_o  <= '0;
         oob_o         <= 1'b0;
         txn_count_o   <= '0;
      end else begin
         data_gnt_o    <= 1'b0;
         data_rvalid_o <= 1'b0;
         data_rdata_o  <= '0;
         case (state)
            S_IDLE: begin
               if (data_req_i) begin
                  state <= S_GNT_WAIT;
                  dcnt  <= '0;
               end
            end
            S_GNT_WAIT: begin
               if (!data_req_i) begin
                  state <= S_IDLE;
               end else if (dcnt == DLY_LAST) begin
                  if (!stall) begin
                     state      <= S_GRANT;
                     data_gnt_o <= 1'b1;
                  end
               end else begin
                  dcnt <= dcnt + 4'd1;
               end
            end
            S_GRANT: begin
               rd_word <= resp_word;
               if (oob_hit) oob_o <= 1'b1;
               // rvalid is registered, so it is raised on the edge entering its cycle.
               if (RVALID_LATENCY == 1) begin
                  state         <= S_IDLE;
                  data_rvalid_o <= 1'b1;
                  data_rdata_o  <= resp_word;
                  txn_count_o   <= txn_count_o + 32'd1;
               end else begin
                  state <= S_RESP;
                  lcnt  <= 4'd1;
               end
            end
            S_RESP: begin
               if (lcnt == LAT_LAST) begin
                  state         <= S_IDLE;
                  data_rvalid_o <= 1'b1;
                  data_rdata_o  <= rd_word;
                  txn_count_o   <= txn_count_o + 32'd1;
               end else begin
                  lcnt <= lcnt + 4'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised self-checking bench: three responders with different grant/latency settings against a word-array model.
// Honours DATA_MEM_RESPONDER_RANDOM_STALL_EN by relaxing grant timing to a lower bound.
module tb_data_mem_responder;
   localparam int N = 3;
   localparam int MEM_WORDS = 1024;
   localparam int GD [N] = '{0, 3, 1};
   localparam int RL [N] = '{1, 4, 3};

   logic        clk = 1'b0;
   logic        rst_n  [N];
   logic        req    [N];
   logic [15:0] addr   [N];
   logic        we     [N];
   logic [3:0]  be     [N];
   logic [31:0] wdata  [N];
   logic        gnt    [N];
   logic        rvalid [N];
   logic [31:0] rdata  [N];
   logic        oob    [N];
   logic [31:0] txn    [N];

   logic [31:0] model   [N][MEM_WORDS];
   bit          written [N][MEM_WORDS];
   logic [31:0] txn_exp [N];
   logic        oob_exp [N];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < N; k++) begin : g_dut
      data_mem_responder #(
         .ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_WORDS(MEM_WORDS),
         .GNT_DELAY(GD[k]), .RVALID_LATENCY(RL[k])
      ) u_dut (
         .clk(clk), .rst_n(rst_n[k]),
         .data_req_i(req[k]), .data_addr_i(addr[k]), .data_we_i(we[k]),
         .data_be_i(be[k]), .data_wdata_i(wdata[k]),
         .data_gnt_o(gnt[k]), .data_rvalid_o(rvalid[k]), .data_rdata_o(rdata[k]),
         .oob_o(oob[k]), .txn_count_o(txn[k])
      );
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   // Waits for gnt on instance k; n counts edges from the one that first samples req.
   task automatic wait_gnt(input int k, output int n, output bit ok);
      n  = 0;
      ok = 0;
      while (!ok && n < 300) begin
         @(posedge clk); #1;
         n++;
         if (n == 1) check_val("rvalid_pulse_end", 32'(rvalid[k]), 0);
         if (gnt[k]) ok = 1;
      end
      if (!ok) check_val("gnt_timeout", 0, 1);
      else begin
`ifdef DATA_MEM_RESPONDER_RANDOM_STALL_EN
         check_val("gnt_lat_min", 32'(n >= GD[k] + 2), 1);
`else
         check_val("gnt_lat", 32'(n), 32'(GD[k] + 2));
`endif
      end
   endtask

   task automatic do_txn(input int k, input logic w, input logic [15:0] a,
                         input logic [3:0] bytes, input logic [31:0] wd);
      int n;
      bit ok;
      int widx;
      bit cmp;
      logic [31:0] exp_rd;
      widx = (int'(a) / 4) % MEM_WORDS;
      @(negedge clk);
      req[k] = 1; we[k] = w; addr[k] = a; be[k] = bytes; wdata[k] = wd;
      wait_gnt(k, n, ok);
      if (!ok) begin
         req[k] = 0;
         return;
      end
      cmp = 1;
      exp_rd = 0;
      if (w) begin
         for (int b = 0; b < 4; b++)
            if (bytes[b]) model[k][widx][8*b +: 8] = wd[8*b +: 8];
         written[k][widx] = 1;
      end else begin
         cmp = written[k][widx];
         exp_rd = model[k][widx];
      end
      if (int'(a) >= MEM_WORDS * 4) oob_exp[k] = 1;
      @(posedge clk); #1;
      req[k] = 0; we[k] = $urandom_range(0, 1); addr[k] = 16'($urandom);
      be[k] = 4'($urandom); wdata[k] = $urandom;
      check_val("gnt_one_cycle", 32'(gnt[k]), 0);
      if (RL[k] > 1) check_val("rdata_idle", rdata[k], 0);
      n = 1;
      ok = rvalid[k];
      while (!ok && n < 40) begin
         @(posedge clk); #1;
         n++;
         ok = rvalid[k];
      end
      if (!ok) begin
         check_val("rvalid_timeout", 0, 1);
         return;
      end
      check_val("rvalid_lat", 32'(n), 32'(RL[k]));
      if (cmp) check_val(w ? "wr_rdata_zero" : "rd_data", rdata[k], exp_rd);
      txn_exp[k]++;
      check_val("txn_count", txn[k], txn_exp[k]);
      check_val("oob", 32'(oob[k]), 32'(oob_exp[k]));
   endtask

   initial begin
      int n;
      bit ok;
      int hits;
      logic [15:0] a;
      for (int k = 0; k < N; k++) begin
         rst_n[k] = 0; req[k] = 0; addr[k] = 0; we[k] = 0; be[k] = 0; wdata[k] = 0;
         txn_exp[k] = 0; oob_exp[k] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         check_val("rst_gnt", 32'(gnt[k]), 0);
         check_val("rst_rvalid", 32'(rvalid[k]), 0);
         check_val("rst_rdata", rdata[k], 0);
         check_val("rst_oob", 32'(oob[k]), 0);
         check_val("rst_txn", txn[k], 0);
         rst_n[k] = 1;
      end

      // basic write then read
      do_txn(0, 1, 16'h0010, 4'hF, 32'hDEADBEEF);
      do_txn(0, 0, 16'h0010, 4'h0, 32'h0);
      check_val("txn_after_two", txn[0], 2);

      // byte enables, including an empty-mask write
      do_txn(0, 1, 16'h0020, 4'hF, 32'h11223344);
      do_txn(0, 1, 16'h0020, 4'b0101, 32'hAABBCCDD);
      do_txn(0, 1, 16'h0021, 4'h0, 32'hFFFFFFFF);
      do_txn(0, 0, 16'h0020, 4'h0, 32'h0);
      check_val("be_merge", rdata[0], 32'h11BB33DD);

      // aliasing and sticky oob
      do_txn(0, 1, 16'h1004, 4'hF, 32'h00000005);
      do_txn(0, 0, 16'h0004, 4'h0, 32'h0);
      check_val("alias_rd", rdata[0], 32'h5);
      do_txn(0, 0, 16'h0010, 4'h0, 32'h0);
      check_val("oob_sticky", 32'(oob[0]), 1);

      // longer delay/latency instance, then an abandoned request
      do_txn(1, 1, 16'h0100, 4'hF, 32'h0BADCAFE);
      do_txn(1, 0, 16'h0100, 4'h0, 32'h0);
      @(negedge clk);
      req[1] = 1; we[1] = 0; addr[1] = 16'h0100;
      repeat (2) @(posedge clk);
      #1;
      req[1] = 0;
      hits = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (gnt[1] || rvalid[1]) hits++;
      end
      check_val("drop_no_handshake", 32'(hits), 0);
      check_val("drop_txn", txn[1], txn_exp[1]);

      // reset during the response window
      do_txn(2, 1, 16'h0040, 4'hF, 32'hCAFEF00D);
      @(negedge clk);
      req[2] = 1; we[2] = 0; addr[2] = 16'h0040;
      wait_gnt(2, n, ok);
      @(posedge clk); #1;
      req[2] = 0;
      rst_n[2] = 0;
      @(posedge clk); #1;
      check_val("rstmid_gnt", 32'(gnt[2]), 0);
      check_val("rstmid_rvalid", 32'(rvalid[2]), 0);
      check_val("rstmid_rdata", rdata[2], 0);
      check_val("rstmid_txn", txn[2], 0);
      txn_exp[2] = 0;
      oob_exp[2] = 0;
      @(posedge clk); #1;
      rst_n[2] = 1;
      hits = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (rvalid[2]) hits++;
      end
      check_val("rstmid_no_rvalid", 32'(hits), 0);
      do_txn(2, 0, 16'h0040, 4'h0, 32'h0);
      check_val("rstmid_mem_kept", rdata[2], 32'hCAFEF00D);

      // random mixed traffic on every instance
      for (int i = 0; i < 70; i++) begin
         for (int k = 0; k < N; k++) begin
            a = 16'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | 16'h1000;
            do_txn(k, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
